// File: rtl/mem_stage.sv
// mem_stage: MEM stage of the 5-stage MIPS pipeline.
//
// The stage holds the byte-addressed, little-endian data memory (MEM_DEPTH
// 32-bit words) and the MEM/WB pipeline register.
//
// Data memory:
//   - Stores are byte, halfword or word sized.
//   - Loads are combinational. The lane is selected first, then sign- or
//     zero-extended according to bhw_type.
//   - The extended load result is captured in the MEM/WB register.
//   - Addresses wrap modulo MEM_DEPTH*4.
//   - Misaligned halfword and word accesses are not trapped.
//
// Halt:
//   - o_halted is a sticky flag, set one edge after a HALT reaches WB.
//   - Once it is set, the pipeline register and the memory no longer update.
//
// Ports:
//   i_clk, i_reset      clock; asynchronous active-high reset
//   i_enable            pipeline advance enable (0 freezes all state)
//   i_ex_m_*            EX/MEM register contents (alu result/address, store
//                       data, rd, mem_read, mem_write, mem_to_reg, reg_write,
//                       bhw_type, halt)
//   i_du_mem_addr       debug word index
//   o_du_mem_data       debug word read (combinational)
//   o_m_wb_*            registered MEM/WB contents
//   o_m_wb_data_write   write-back value (memory data or ALU result)
//   o_halted            sticky halt flag
module mem_stage #(
    parameter int MEM_DEPTH = 64,
    parameter int ADDR_W    = 6
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_enable,
    input  logic [31:0]       i_ex_m_alu_result,
    input  logic [31:0]       i_ex_m_write_data,
    input  logic [4:0]        i_ex_m_rd,
    input  logic              i_ex_m_mem_read,
    input  logic              i_ex_m_mem_write,
    input  logic              i_ex_m_mem_to_reg,
    input  logic              i_ex_m_reg_write,
    input  logic [2:0]        i_ex_m_bhw_type,
    input  logic              i_ex_m_halt,
    input  logic [ADDR_W-1:0] i_du_mem_addr,
    output logic [31:0]       o_du_mem_data,
    output logic [31:0]       o_m_wb_read_data,
    output logic [31:0]       o_m_wb_alu_result,
    output logic [4:0]        o_m_wb_rd,
    output logic              o_m_wb_reg_write,
    output logic              o_m_wb_mem_to_reg,
    output logic              o_m_wb_halt,
    output logic [31:0]       o_m_wb_data_write,
    output logic              o_halted
);

    localparam logic [2:0] BHW_B  = 3'b000;
    localparam logic [2:0] BHW_H  = 3'b001;
    localparam logic [2:0] BHW_BU = 3'b011;
    localparam logic [2:0] BHW_HU = 3'b100;

    logic [31:0]       mem [MEM_DEPTH];
    logic [ADDR_W-1:0] word_idx;
    logic [1:0]        byte_lane;
    logic              advance;
    logic              store_en;
    logic [3:0]        byte_en;
    logic [31:0]       store_lanes;
    logic [31:0]       rd_word;
    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;
    logic [31:0]       load_data;

    // Bits above the word index are ignored, so addresses alias modulo
    // the memory size.
    assign word_idx  = i_ex_m_alu_result[ADDR_W+1:2];
    assign byte_lane = i_ex_m_alu_result[1:0];

    // A set halt flag freezes the stage exactly like i_enable=0.
    assign advance  = i_enable && !o_halted;
    assign store_en = advance && i_ex_m_mem_write;

    // Store lane steering.
    // The store data is replicated across all lanes, so the byte enables
    // alone choose which bytes are written.
    always_comb begin
        byte_en     = 4'b1111;
        store_lanes = i_ex_m_write_data;
        case (i_ex_m_bhw_type)
            BHW_B, BHW_BU: begin
                byte_en     = 4'b0001 << byte_lane;
                store_lanes = {4{i_ex_m_write_data[7:0]}};
            end
            BHW_H, BHW_HU: begin
                byte_en     = byte_lane[1] ? 4'b1100 : 4'b0011;
                store_lanes = {2{i_ex_m_write_data[15:0]}};
            end
            default: begin
                byte_en     = 4'b1111;
                store_lanes = i_ex_m_write_data;
            end
        endcase
    end

    // Combinational load path: lane select followed by extension.
    // Undefined bhw codes read the full word.
    assign rd_word = mem[word_idx];
    assign rd_byte = rd_word[8*byte_lane +: 8];
    assign rd_half = byte_lane[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        load_data = rd_word;
        case (i_ex_m_bhw_type)
            BHW_B:   load_data = {{24{rd_byte[7]}}, rd_byte};
            BHW_H:   load_data = {{16{rd_half[15]}}, rd_half};
            BHW_BU:  load_data = {24'd0, rd_byte};
            BHW_HU:  load_data = {16'd0, rd_half};
            default: load_data = rd_word;
        endcase
    end

    // Data memory.
    // The asynchronous reset clears every word and drops any store that
    // is in flight.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (store_en) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem[word_idx][8*b +: 8] <= store_lanes[8*b +: 8];
                end
            end
        end
    end

    // MEM/WB pipeline register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_m_wb_read_data  <= '0;
            o_m_wb_alu_result <= '0;
            o_m_wb_rd         <= '0;
            o_m_wb_reg_write  <= 1'b0;
            o_m_wb_mem_to_reg <= 1'b0;
            o_m_wb_halt       <= 1'b0;
        end else if (advance) begin
            o_m_wb_read_data  <= load_data;
            o_m_wb_alu_result <= i_ex_m_alu_result;
            o_m_wb_rd         <= i_ex_m_rd;
            o_m_wb_reg_write  <= i_ex_m_reg_write;
            o_m_wb_mem_to_reg <= i_ex_m_mem_to_reg;
            o_m_wb_halt       <= i_ex_m_halt;
        end
    end

    // Sticky halt flag.
    // It is set when a HALT sits in WB on an enabled edge.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_halted <= 1'b0;
        end else if (i_enable && o_m_wb_halt) begin
            o_halted <= 1'b1;
        end
    end

    assign o_m_wb_data_write = o_m_wb_mem_to_reg ? o_m_wb_read_data : o_m_wb_alu_result;
    assign o_du_mem_data     = mem[i_du_mem_addr];

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    localparam int MEM_DEPTH = 64;
    localparam int ADDR_W    = 6;

    // ---------------- clock / reset ----------------
    logic              i_clk = 1'b0;
    logic              i_reset;
    logic              i_enable;
    logic [31:0]       i_ex_m_alu_result;
    logic [31:0]       i_ex_m_write_data;
    logic [4:0]        i_ex_m_rd;
    logic              i_ex_m_mem_read;
    logic              i_ex_m_mem_write;
    logic              i_ex_m_mem_to_reg;
    logic              i_ex_m_reg_write;
    logic [2:0]        i_ex_m_bhw_type;
    logic              i_ex_m_halt;
    logic [ADDR_W-1:0] i_du_mem_addr;
    logic [31:0]       o_du_mem_data;
    logic [31:0]       o_m_wb_read_data;
    logic [31:0]       o_m_wb_alu_result;
    logic [4:0]        o_m_wb_rd;
    logic              o_m_wb_reg_write;
    logic              o_m_wb_mem_to_reg;
    logic              o_m_wb_halt;
    logic [31:0]       o_m_wb_data_write;
    logic              o_halted;

    always #5 i_clk = ~i_clk;

    mem_stage #(.MEM_DEPTH(MEM_DEPTH), .ADDR_W(ADDR_W)) dut (
        .i_clk             (i_clk),
        .i_reset           (i_reset),
        .i_enable          (i_enable),
        .i_ex_m_alu_result (i_ex_m_alu_result),
        .i_ex_m_write_data (i_ex_m_write_data),
        .i_ex_m_rd         (i_ex_m_rd),
        .i_ex_m_mem_read   (i_ex_m_mem_read),
        .i_ex_m_mem_write  (i_ex_m_mem_write),
        .i_ex_m_mem_to_reg (i_ex_m_mem_to_reg),
        .i_ex_m_reg_write  (i_ex_m_reg_write),
        .i_ex_m_bhw_type   (i_ex_m_bhw_type),
        .i_ex_m_halt       (i_ex_m_halt),
        .i_du_mem_addr     (i_du_mem_addr),
        .o_du_mem_data     (o_du_mem_data),
        .o_m_wb_read_data  (o_m_wb_read_data),
        .o_m_wb_alu_result (o_m_wb_alu_result),
        .o_m_wb_rd         (o_m_wb_rd),
        .o_m_wb_reg_write  (o_m_wb_reg_write),
        .o_m_wb_mem_to_reg (o_m_wb_mem_to_reg),
        .o_m_wb_halt       (o_m_wb_halt),
        .o_m_wb_data_write (o_m_wb_data_write),
        .o_halted          (o_halted)
    );

    // ---------------- scoreboard state ----------------
    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q[$];      // expected write-back value per instruction
    logic [31:0] exp_ld_q[$];   // expected extended load value per instruction
    logic [31:0] model_mem [MEM_DEPTH];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    // Reference load: pick the lane by shifting, then extend.
    function automatic logic [31:0] model_load(input logic [31:0] word, input logic [1:0] a,
                                               input logic [2:0] bhw);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(word >> (8 * a));
        h = 16'(word >> (a[1] ? 16 : 0));
        case (bhw)
            3'b000:  return 32'($signed(b));
            3'b001:  return 32'($signed(h));
            3'b011:  return {24'd0, b};
            3'b100:  return {16'd0, h};
            default: return word;
        endcase
    endfunction

    task automatic model_store(input logic [31:0] addr, input logic [31:0] wd, input logic [2:0] bhw);
        int idx;
        idx = int'(addr[7:2]);
        case (bhw)
            3'b000, 3'b011: model_mem[idx][8*addr[1:0] +: 8] = wd[7:0];
            3'b001, 3'b100: model_mem[idx][16*addr[1] +: 16] = wd[15:0];
            default:        model_mem[idx] = wd;
        endcase
    endtask

    task automatic drive_idle();
        i_enable          = 1'b1;
        i_ex_m_alu_result = '0;
        i_ex_m_write_data = '0;
        i_ex_m_rd         = '0;
        i_ex_m_mem_read   = 1'b0;
        i_ex_m_mem_write  = 1'b0;
        i_ex_m_mem_to_reg = 1'b0;
        i_ex_m_reg_write  = 1'b0;
        i_ex_m_bhw_type   = 3'b010;
        i_ex_m_halt       = 1'b0;
    endtask

    // ---------------- driver ----------------
    // Issues one enabled instruction, then checks what reaches WB after the edge.
    task automatic op(input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd,
                      input logic mr, input logic mw, input logic m2r, input logic [2:0] bhw);
        logic [31:0] ld;
        logic [31:0] e;
        @(negedge i_clk);
        i_enable          = 1'b1;
        i_ex_m_alu_result = alu;
        i_ex_m_write_data = wd;
        i_ex_m_rd         = rd;
        i_ex_m_mem_read   = mr;
        i_ex_m_mem_write  = mw;
        i_ex_m_mem_to_reg = m2r;
        i_ex_m_reg_write  = !mw;
        i_ex_m_bhw_type   = bhw;
        i_ex_m_halt       = 1'b0;
        ld = model_load(model_mem[alu[7:2]], alu[1:0], bhw);
        exp_q.push_back(m2r ? ld : alu);
        exp_ld_q.push_back(ld);
        if (mw) model_store(alu, wd, bhw);
        @(posedge i_clk);
        #1;
        if (exp_q.size() == 0 || exp_ld_q.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check("wb_data", o_m_wb_data_write, e);
            e = exp_ld_q.pop_front();
            check("wb_read_data", o_m_wb_read_data, e);
        end
        check("wb_rd", {27'd0, o_m_wb_rd}, {27'd0, rd});
        check("wb_reg_write", {31'd0, o_m_wb_reg_write}, {31'd0, !mw});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] a;
        logic [2:0]  t;
        for (int i = 0; i < MEM_DEPTH; i++) model_mem[i] = '0;
        i_reset       = 1'b1;
        i_du_mem_addr = '0;
        drive_idle();
        repeat (3) @(posedge i_clk);
        #1;
        check("rst_wb_data", o_m_wb_data_write, 32'd0);
        check("rst_wb_alu", o_m_wb_alu_result, 32'd0);
        check("rst_wb_read", o_m_wb_read_data, 32'd0);
        check("rst_wb_ctl", {24'd0, o_m_wb_rd, o_m_wb_reg_write, o_m_wb_mem_to_reg, o_m_wb_halt},
              32'd0);
        check("rst_halted", {31'd0, o_halted}, 32'd0);
        @(negedge i_clk);
        i_reset = 1'b0;
        for (int i = 0; i < MEM_DEPTH; i++) begin
            i_du_mem_addr = ADDR_W'(i);
            #1;
            check("rst_mem", o_du_mem_data, 32'd0);
        end

        // Word store, then word load.
        op(32'h8, 32'hDEADBEEF, 5'd1, 1'b0, 1'b1, 1'b0, 3'b010);
        op(32'h8, 32'h0, 5'd2, 1'b1, 1'b0, 1'b1, 3'b010);
        check("lw_8", o_m_wb_data_write, 32'hDEADBEEF);

        // Byte and halfword stores/loads on a cleared word.
        op(32'h8, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0, 3'b010);
        op(32'h9, 32'h80, 5'd0, 1'b0, 1'b1, 1'b0, 3'b000);
        i_du_mem_addr = 6'd2;
        #1 check("sb_word", o_du_mem_data, 32'h00008000);
        op(32'h9, 32'h0, 5'd3, 1'b1, 1'b0, 1'b1, 3'b000);
        check("lb_9", o_m_wb_data_write, 32'hFFFFFF80);
        op(32'h9, 32'h0, 5'd3, 1'b1, 1'b0, 1'b1, 3'b011);
        check("lbu_9", o_m_wb_data_write, 32'h00000080);
        op(32'hA, 32'h8001, 5'd0, 1'b0, 1'b1, 1'b0, 3'b001);
        op(32'hA, 32'h0, 5'd4, 1'b1, 1'b0, 1'b1, 3'b001);
        check("lh_a", o_m_wb_data_write, 32'hFFFF8001);
        op(32'hA, 32'h0, 5'd4, 1'b1, 1'b0, 1'b1, 3'b100);
        check("lhu_a", o_m_wb_data_write, 32'h00008001);

        // ALU result passes through to write-back.
        op(32'h12345678, 32'h0, 5'd7, 1'b0, 1'b0, 1'b0, 3'b010);
        check("alu_wb", o_m_wb_data_write, 32'h12345678);

        // Enable low with a store pending: everything holds.
        @(negedge i_clk);
        i_enable          = 1'b0;
        i_ex_m_alu_result = 32'h8;
        i_ex_m_write_data = 32'hAAAA5555;
        i_ex_m_rd         = 5'd9;
        i_ex_m_mem_write  = 1'b1;
        i_ex_m_reg_write  = 1'b1;
        i_ex_m_bhw_type   = 3'b010;
        @(posedge i_clk);
        #1;
        check("hold_wb", o_m_wb_data_write, 32'h12345678);
        check("hold_rd", {27'd0, o_m_wb_rd}, 32'd7);
        i_du_mem_addr = 6'd2;
        #1 check("hold_mem", o_du_mem_data, 32'h80018000);

        // Address 0x100 aliases word 0.
        op(32'h100, 32'h00000055, 5'd0, 1'b0, 1'b1, 1'b0, 3'b010);
        op(32'h0, 32'h0, 5'd5, 1'b1, 1'b0, 1'b1, 3'b010);
        check("alias_ld", o_m_wb_data_write, 32'h00000055);

        // Debug read sees the old word until the store edge.
        @(negedge i_clk);
        i_enable          = 1'b1;
        i_ex_m_alu_result = 32'h10;
        i_ex_m_write_data = 32'hCAFEF00D;
        i_ex_m_mem_write  = 1'b1;
        i_ex_m_mem_read   = 1'b0;
        i_ex_m_reg_write  = 1'b0;
        i_ex_m_mem_to_reg = 1'b0;
        i_ex_m_bhw_type   = 3'b010;
        i_du_mem_addr     = 6'd4;
        #1 check("du_before", o_du_mem_data, 32'h0);
        @(posedge i_clk);
        #1 check("du_after", o_du_mem_data, 32'hCAFEF00D);
        model_mem[4] = 32'hCAFEF00D;

        // Random mix of loads/stores checked through the scoreboard.
        for (int n = 0; n < 60; n++) begin
            a = {24'($urandom_range(0, 3)), 8'($urandom_range(0, 255))};
            t = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1)
                op(a, $urandom, 5'($urandom_range(0, 31)), 1'b0, 1'b1, 1'b0, t);
            else
                op(a, 32'h0, 5'($urandom_range(0, 31)), 1'b1, 1'b0, 1'($urandom_range(0, 1)), t);
        end
        for (int i = 0; i < MEM_DEPTH; i++) begin
            i_du_mem_addr = ADDR_W'(i);
            #1 check("rand_mem", o_du_mem_data, model_mem[i]);
        end

        // HALT: WB flag one edge later, sticky flag the edge after.
        @(negedge i_clk);
        drive_idle();
        i_ex_m_alu_result = 32'h0BADCAFE;
        i_ex_m_halt       = 1'b1;
        @(posedge i_clk);
        #1;
        check("halt_wb", {31'd0, o_m_wb_halt}, 32'd1);
        check("halt_not_yet", {31'd0, o_halted}, 32'd0);
        @(negedge i_clk);
        drive_idle();
        i_ex_m_alu_result = 32'h0BADCAFE;
        @(posedge i_clk);
        #1 check("halted_set", {31'd0, o_halted}, 32'd1);
        @(negedge i_clk);
        i_ex_m_alu_result = 32'h14;
        i_ex_m_write_data = 32'h77777777;
        i_ex_m_mem_write  = 1'b1;
        i_ex_m_bhw_type   = 3'b010;
        i_du_mem_addr     = 6'd5;
        @(posedge i_clk);
        #1;
        check("halted_no_store", o_du_mem_data, model_mem[5]);
        check("halted_wb_hold", o_m_wb_alu_result, 32'h0BADCAFE);
        check("halted_sticky", {31'd0, o_halted}, 32'd1);

        // Reset asserted mid-store: store is dropped, flag clears at once.
        @(negedge i_clk);
        i_ex_m_alu_result = 32'h18;
        i_ex_m_write_data = 32'h99999999;
        i_ex_m_mem_write  = 1'b1;
        i_du_mem_addr     = 6'd6;
        i_reset           = 1'b1;
        #1;
        check("rst_mid_halted", {31'd0, o_halted}, 32'd0);
        check("rst_mid_wb", o_m_wb_alu_result, 32'd0);
        @(posedge i_clk);
        #1 check("rst_mid_mem", o_du_mem_data, 32'd0);
        @(negedge i_clk);
        drive_idle();
        i_reset = 1'b0;
        @(posedge i_clk);
        #1;
        check("post_rst_mem", o_du_mem_data, 32'd0);
        i_du_mem_addr = 6'd4;
        #1 check("post_rst_mem4", o_du_mem_data, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM stage of the 5-stage MIPS pipeline. It sits directly downstream of the EX stage and consumes the EX/MEM register contents: ALU result, store data, rd, control bits, bhw type and halt.
- Contains the byte-addressed data memory with byte/halfword/word load and store handling, and the MEM/WB pipeline register.
- Produces the WB write-back value that EX uses for forwarding (i_m_wb_data_write), plus a debug read port for the debug unit.

Parameters:
- MEM_DEPTH, 64, number of 32-bit words in data memory.
- ADDR_W, 6, word-index width; must equal log2(MEM_DEPTH).

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_enable  in  1  pipeline advance enable (debug step mode); 0 freezes all state.
- i_ex_m_alu_result  in  32  effective byte address, or ALU value for writeback.
- i_ex_m_write_data  in  32  store data (already forwarded).
- i_ex_m_rd  in  5  destination register.
- i_ex_m_mem_read  in  1  load.
- i_ex_m_mem_write  in  1  store.
- i_ex_m_mem_to_reg  in  1  writeback selects memory data.
- i_ex_m_reg_write  in  1  register write enable.
- i_ex_m_bhw_type  in  3  access type: 000 B, 001 H, 010 W, 011 BU, 100 HU.
- i_ex_m_halt  in  1  HALT instruction marker.
- i_du_mem_addr  in  ADDR_W  debug word index.
- o_du_mem_data  out  32  debug word read, combinational.
- o_m_wb_read_data  out  32  registered load result, extended.
- o_m_wb_alu_result  out  32  registered ALU result.
- o_m_wb_rd  out  5  registered rd.
- o_m_wb_reg_write  out  1  registered reg_write.
- o_m_wb_mem_to_reg  out  1  registered mem_to_reg.
- o_m_wb_halt  out  1  registered halt.
- o_m_wb_data_write  out  32  o_m_wb_mem_to_reg ? o_m_wb_read_data : o_m_wb_alu_result; feeds EX forwarding and the register file.
- o_halted  out  1  sticky: program reached WB with halt set.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-operation):
  - All MEM/WB outputs = 0, o_halted = 0.
  - Every memory word = 0.
  - An in-flight store is discarded.
- Addressing and endianness:
  - Word index = alu_result[ADDR_W+1:2]; higher address bits are ignored, so addresses wrap modulo MEM_DEPTH*4.
  - Little-endian. Byte lane = alu_result[1:0]; halfword lane = alu_result[1].
  - Misaligned H/W accesses are not trapped. H ignores bit 0; W ignores bits [1:0].
- Store (mem_write=1, i_enable=1), at the rising edge:
  - B: writes byte lane with write_data[7:0].
  - H: writes halfword lane with write_data[15:0].
  - W: writes the full word.
  - Unselected bytes are unchanged.
  - bhw types 011/100 on a store are treated as B/H respectively.
- Load (combinational read of the addressed word):
  - Selects the lane, then extends: B/H sign-extend, BU/HU zero-extend, W passes through.
  - bhw values 101–111 act as W.
  - The result is captured in o_m_wb_read_data at the edge, so load data appears in WB one cycle after the instruction enters MEM.
  - When mem_read=0, read_data is still captured (don't-care, deterministic lane extract).
- MEM/WB register:
  - On each edge with i_enable=1, captures alu_result, rd, reg_write, mem_to_reg, halt and read_data.
  - i_enable=0 holds all registers and memory; no store occurs.
- Store and load to the same word in one cycle cannot occur (single port). The debug read of a word being stored returns the old value until the edge, the new value after.
- o_halted:
  - Set on the edge after o_m_wb_halt=1 (registered from o_m_wb_halt while i_enable=1).
  - Stays 1 until reset.
  - Once set, the MEM/WB register and memory stop updating regardless of i_enable.
- No combinational path from any EX/MEM input to any MEM/WB output, except through memory into the registered read_data.

Test Plan:
- Reset then debug-read all indices -> every o_du_mem_data = 0. All MEM/WB outputs = 0 and o_halted = 0.
- SW 0xDEADBEEF at addr 0x8, then LW addr 0x8 -> o_m_wb_read_data = 0xDEADBEEF one edge after the load. mem_to_reg=1 -> o_m_wb_data_write = 0xDEADBEEF.
- SB 0x80 at addr 0x9 onto a zero word:
  - word = 0x00008000.
  - LB 0x9 -> 0xFFFFFF80; LBU 0x9 -> 0x00000080.
  - SH 0x8001 at 0xA, then LH 0xA -> 0xFFFF8001; LHU 0xA -> 0x00008001.
- ALU op with mem_to_reg=0, alu_result=0x12345678, rd=7, reg_write=1 -> next cycle o_m_wb_data_write=0x12345678, rd=7. With i_enable=0 plus a store -> outputs and memory unchanged.
- Address 0x100 (MEM_DEPTH=64) -> aliases word 0. Store then read at 0x0 returns the stored value.
- halt=1 enters -> o_m_wb_halt=1 next edge and o_halted=1 the edge after. Further stores are ignored. Assert i_reset mid-store -> memory word stays 0 and o_halted clears.
